// File: rtl/control_hazard_stage.sv
//------------------------------------------------------------------------------
// Module  : control_hazard_stage
// Brief   : Load-use stall / flush control for the ID/EX boundary, bubble stats.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_hazard_stage #(
    parameter int CTRL_W       = 16,
    parameter int ADDR_W       = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [CTRL_W-1:0] PreCtrl,
    input  logic [ADDR_W-1:0] IDRs,
    input  logic [ADDR_W-1:0] IDRt,
    input  logic              IDUsesRt,
    input  logic              EXMemRead,
    input  logic [ADDR_W-1:0] EXDstAddr,
    input  logic              FlushReq,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              Stalling,
    output logic [CNT_W-1:0]  BubbleCount
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [3:0] C_STALL_RELOAD = 4'(STALL_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_stall_cnt;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic              w_update_en;
    logic [CNT_W-1:0]  w_bubble_next;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign w_hazard = EXMemRead && (EXDstAddr != '0) &&
                      ((EXDstAddr == IDRs) || (IDUsesRt && (EXDstAddr == IDRt)));

    assign w_bubble_next = (r_bubble_cnt == {CNT_W{1'b1}}) ? r_bubble_cnt
                                                           : r_bubble_cnt + CNT_W'(1);

    always_comb begin
        w_update_en = 1'b1;
        if (!Rst) begin
            case (r_state)
                S_RUN:   w_update_en = FlushReq || !w_hazard;
                S_STALL: w_update_en = FlushReq;
                default: w_update_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_RUN;
            r_stall_cnt  <= 4'd0;
            r_ctrl       <= '0;
            r_bubble_cnt <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (FlushReq) begin
                        r_ctrl       <= '0;
                        r_bubble_cnt <= w_bubble_next;
                    end else if (w_hazard) begin
                        r_ctrl       <= '0;
                        r_bubble_cnt <= w_bubble_next;
                        // A single-bubble stall is fully handled in RUN.
                        if (STALL_CYCLES > 1) begin
                            r_state     <= S_STALL;
                            r_stall_cnt <= C_STALL_RELOAD;
                        end
                    end else begin
                        r_ctrl <= PreCtrl;
                    end
                end
                S_STALL: begin
                    r_ctrl       <= '0;
                    r_bubble_cnt <= w_bubble_next;
                    if (FlushReq) begin
                        r_state     <= S_RUN;
                        r_stall_cnt <= 4'd0;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 4'd1;
                        if (r_stall_cnt == 4'd1) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state     <= S_RUN;
                    r_stall_cnt <= 4'd0;
                    r_ctrl      <= '0;
                end
            endcase
        end
    end

    assign CtrlOut     = r_ctrl;
    assign PCWrite     = w_update_en;
    assign IFIDWrite   = w_update_en;
    assign Stalling    = (r_state == S_STALL);
    assign BubbleCount = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_control_hazard_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_control_hazard_stage
// Brief   : Directed checks of control_hazard_stage for 1-/3-cycle stalls and 4-bit saturation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_hazard_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] PreCtrl;
    logic [4:0]  IDRs, IDRt, EXDstAddr;
    logic        IDUsesRt, EXMemRead, FlushReq;

    logic [15:0] ctrl1, ctrl3, ctrl4;
    logic        pcw1, pcw3, pcw4, ifw1, ifw3, ifw4, stl1, stl3, stl4;
    logic [15:0] cnt1, cnt3;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    control_hazard_stage #(.CTRL_W(16), .ADDR_W(5), .STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .Clk(Clk), .Rst(Rst), .PreCtrl(PreCtrl), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXDstAddr(EXDstAddr),
        .FlushReq(FlushReq), .CtrlOut(ctrl1), .PCWrite(pcw1), .IFIDWrite(ifw1),
        .Stalling(stl1), .BubbleCount(cnt1));

    control_hazard_stage #(.CTRL_W(16), .ADDR_W(5), .STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .Clk(Clk), .Rst(Rst), .PreCtrl(PreCtrl), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXDstAddr(EXDstAddr),
        .FlushReq(FlushReq), .CtrlOut(ctrl3), .PCWrite(pcw3), .IFIDWrite(ifw3),
        .Stalling(stl3), .BubbleCount(cnt3));

    control_hazard_stage #(.CTRL_W(16), .ADDR_W(5), .STALL_CYCLES(1), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .PreCtrl(PreCtrl), .IDRs(IDRs), .IDRt(IDRt),
        .IDUsesRt(IDUsesRt), .EXMemRead(EXMemRead), .EXDstAddr(EXDstAddr),
        .FlushReq(FlushReq), .CtrlOut(ctrl4), .PCWrite(pcw4), .IFIDWrite(ifw4),
        .Stalling(stl4), .BubbleCount(cnt4));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        PreCtrl   = 16'h0000;
        IDRs      = 5'd0;
        IDRt      = 5'd0;
        IDUsesRt  = 1'b0;
        EXMemRead = 1'b0;
        EXDstAddr = 5'd0;
        FlushReq  = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        clear_inputs();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("reset_ctrl", 32'(ctrl1), 32'h0);
        check("reset_cnt", 32'(cnt1), 32'h0);
        check("reset_stalling", 32'(stl3), 32'h0);
        // Hazard-shaped inputs while reset is held must not block the PC.
        EXMemRead = 1'b1; EXDstAddr = 5'd8; IDRs = 5'd8;
        #1;
        check("reset_pcwrite", 32'(pcw3), 32'h1);
        check("reset_ifidwrite", 32'(ifw1), 32'h1);
        clear_inputs();
        Rst = 1'b0;

        // Plain pass-through.
        PreCtrl = 16'h1A5F;
        #1;
        check("pass_pcwrite", 32'(pcw1), 32'h1);
        tick();
        check("pass_ctrl", 32'(ctrl1), 32'h1A5F);
        check("pass_cnt", 32'(cnt1), 32'h0);

        // Single-bubble load-use via Rs.
        EXMemRead = 1'b1; EXDstAddr = 5'd8; IDRs = 5'd8;
        #1;
        check("lu1_pcwrite", 32'(pcw1), 32'h0);
        check("lu1_ifidwrite", 32'(ifw1), 32'h0);
        tick();
        check("lu1_ctrl", 32'(ctrl1), 32'h0);
        check("lu1_cnt", 32'(cnt1), 32'h1);
        check("lu1_stalling", 32'(stl1), 32'h0);

        // Three-bubble load-use via Rt.
        do_reset();
        PreCtrl = 16'h00C3; EXMemRead = 1'b1; EXDstAddr = 5'd9;
        IDRt = 5'd9; IDUsesRt = 1'b1; IDRs = 5'd3;
        #1;
        check("lu3_pcwrite_e0", 32'(pcw3), 32'h0);
        tick();
        check("lu3_ctrl_e1", 32'(ctrl3), 32'h0);
        check("lu3_stl_e1", 32'(stl3), 32'h1);
        check("lu3_cnt_e1", 32'(cnt3), 32'h1);
        tick();
        check("lu3_ctrl_e2", 32'(ctrl3), 32'h0);
        check("lu3_stl_e2", 32'(stl3), 32'h1);
        check("lu3_cnt_e2", 32'(cnt3), 32'h2);
        check("lu3_pcwrite_e2", 32'(pcw3), 32'h0);
        EXMemRead = 1'b0;
        tick();
        check("lu3_ctrl_e3", 32'(ctrl3), 32'h0);
        check("lu3_stl_e3", 32'(stl3), 32'h0);
        check("lu3_cnt_e3", 32'(cnt3), 32'h3);
        check("lu3_pcwrite_e3", 32'(pcw3), 32'h1);
        tick();
        check("lu3_ctrl_e4", 32'(ctrl3), 32'h00C3);
        check("lu3_cnt_e4", 32'(cnt3), 32'h3);
        // Rt match is irrelevant when the instruction does not read Rt.
        EXMemRead = 1'b1; IDUsesRt = 1'b0;
        #1;
        check("rt_unused_pcwrite", 32'(pcw3), 32'h1);

        // Back-to-back load-use right after a stall ends.
        do_reset();
        EXMemRead = 1'b1; EXDstAddr = 5'd5; IDRs = 5'd5;
        tick(); tick(); tick();
        check("b2b_stl_run", 32'(stl3), 32'h0);
        check("b2b_pcwrite", 32'(pcw3), 32'h0);
        tick();
        check("b2b_stl_again", 32'(stl3), 32'h1);
        check("b2b_cnt", 32'(cnt3), 32'h4);

        // Load into r0 is not a hazard.
        do_reset();
        PreCtrl = 16'hBEEF; EXMemRead = 1'b1; EXDstAddr = 5'd0; IDRs = 5'd0;
        #1;
        check("r0_pcwrite", 32'(pcw1), 32'h1);
        tick();
        check("r0_ctrl", 32'(ctrl1), 32'hBEEF);
        check("r0_cnt", 32'(cnt1), 32'h0);

        // Flush in the second stall cycle, then flush beating a hazard in RUN.
        do_reset();
        PreCtrl = 16'h1234; EXMemRead = 1'b1; EXDstAddr = 5'd7; IDRs = 5'd7;
        tick();
        check("fl_stl_e1", 32'(stl3), 32'h1);
        FlushReq = 1'b1;
        #1;
        check("fl_pcwrite_stall", 32'(pcw3), 32'h1);
        check("fl_ifidwrite_stall", 32'(ifw3), 32'h1);
        tick();
        check("fl_stl_e2", 32'(stl3), 32'h0);
        check("fl_cnt_e2", 32'(cnt3), 32'h2);
        check("fl_ctrl_e2", 32'(ctrl3), 32'h0);
        check("fl_pcwrite_run", 32'(pcw3), 32'h1);
        tick();
        check("fl_cnt_e3", 32'(cnt3), 32'h3);
        check("fl_stl_e3", 32'(stl3), 32'h0);
        check("fl_ctrl_e3", 32'(ctrl3), 32'h0);

        // Reset in the middle of a stall.
        do_reset();
        PreCtrl = 16'h5555; EXMemRead = 1'b1; EXDstAddr = 5'd4; IDRs = 5'd4;
        tick();
        check("rst_mid_stl_before", 32'(stl3), 32'h1);
        Rst = 1'b1;
        #1;
        check("rst_mid_pcwrite", 32'(pcw3), 32'h1);
        tick();
        check("rst_mid_stl", 32'(stl3), 32'h0);
        check("rst_mid_ctrl", 32'(ctrl3), 32'h0);
        check("rst_mid_cnt", 32'(cnt3), 32'h0);
        Rst = 1'b0;
        #1;
        check("rst_release_pcwrite", 32'(pcw3), 32'h0);

        // Saturation of a 4-bit counter.
        do_reset();
        EXMemRead = 1'b1; EXDstAddr = 5'd12; IDRs = 5'd12;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", 32'(cnt4), 32'hF);
        check("sat_stalling", 32'(stl4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
